// File: rtl/tdc_comp_ctrl_pkg.sv
// Shared constants for the TDC compensation sequencer: widths, timeout and
// one-hot state encodings matching the compensation engine.
package tdc_comp_ctrl_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 32;

  // The engine needs this many idle cycles after its done strobe before it can
  // accept the next request; the WRITE/LOAD/DATA path provides three.
  localparam int REQ_GAP_MIN = 2;

  typedef logic [6:0] state_t;

  localparam state_t S_IDLE   = 7'b000_0001;
  localparam state_t S_LOAD   = 7'b000_0010;
  localparam state_t S_DATA   = 7'b000_0100;
  localparam state_t S_REQ    = 7'b000_1000;
  localparam state_t S_WAIT   = 7'b001_0000;
  localparam state_t S_WRITE  = 7'b010_0000;
  localparam state_t S_FINISH = 7'b100_0000;

endpackage

// File: rtl/tdc_req_timer.sv
// Request watchdog: loadable up-counter with synchronous clear that stops and
// flags terminal when it reaches TIMEOUT. Usable by any handshake initiator.
module tdc_req_timer
  import tdc_comp_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_value,
  input  logic             inc,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  assign tc = (count == CNT_W'(TIMEOUT));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order across blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ld) begin
      count <= ld_value;
    end else if (inc && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tdc_comp_ctrl.sv
// Frame sequencer for the TDC compensation engine: reads raw samples, issues
// one engine request per point, and writes the corrected result out.
module tdc_comp_ctrl
  import tdc_comp_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              i_clk_50m,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic [ADDR_W-1:0] i_addr_start,
  input  logic [ADDR_W-1:0] i_addr_end,
  output logic [ADDR_W-1:0] o_ram_rd_addr,
  input  logic [DATA_W-1:0] i_ram_rd_data,
  output logic              o_process_en,
  output logic [ADDR_W-1:0] o_tdc_rd_addr,
  output logic [DATA_W-1:0] o_rise_data,
  input  logic              i_process_done,
  input  logic [DATA_W-1:0] i_process_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] addr_end_q;
  logic              abort;
  logic              timer_tc;

  // The timer starts from zero in the request cycle and counts through WAIT,
  // so a silent engine aborts exactly TIMEOUT cycles after the request pulse.
  tdc_req_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_req_timer (
    .clk      (i_clk_50m),
    .rst_n    (i_rst_n),
    .clr      (state == S_DATA),
    .ld       (1'b0),
    .ld_value ({CNT_W{1'b0}}),
    .inc      ((state == S_REQ) || (state == S_WAIT)),
    .tc       (timer_tc)
  );

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      cur           <= '0;
      addr_end_q    <= '0;
      abort         <= 1'b0;
      o_ram_rd_addr <= '0;
      o_process_en  <= 1'b0;
      o_tdc_rd_addr <= '0;
      o_rise_data   <= '0;
      o_wr_en       <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_busy        <= 1'b0;
      o_frame_done  <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      // NOTE: strobes default low each cycle; a state that wants a pulse
      // overrides below, so no strobe can stick high.
      o_process_en <= 1'b0;
      o_wr_en      <= 1'b0;
      o_frame_done <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (i_frame_start) begin
            addr_end_q    <= i_addr_end;
            cur           <= i_addr_start;
            o_ram_rd_addr <= i_addr_start;
            abort         <= 1'b0;
            o_timeout_err <= 1'b0;
            o_busy        <= 1'b1;
            state         <= S_LOAD;
          end
        end

        S_LOAD: state <= S_DATA;

        // Read data for cur is on the bus this cycle; it and the address are
        // frozen here and stay untouched until the next point's DATA cycle.
        S_DATA: begin
          o_rise_data   <= i_ram_rd_data;
          o_tdc_rd_addr <= cur;
          o_process_en  <= 1'b1;
          state         <= S_REQ;
        end

        S_REQ: state <= S_WAIT;

        S_WAIT: begin
          if (i_process_done) begin
            o_wr_data <= i_process_data;
            o_wr_addr <= cur;
            o_wr_en   <= 1'b1;
            state     <= S_WRITE;
          end else if (timer_tc) begin
            o_wr_data     <= '0;
            o_wr_addr     <= cur;
            o_wr_en       <= 1'b1;
            o_timeout_err <= 1'b1;
            abort         <= 1'b1;
            state         <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (abort || (cur == addr_end_q)) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            state        <= S_FINISH;
          end else begin
            cur           <= cur + 1'b1;
            o_ram_rd_addr <= cur + 1'b1;
            state         <= S_LOAD;
          end
        end

        S_FINISH: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
